fall_through_fifo: RTL and testbench



---
 rtl/fall_through_fifo_pkg.sv | 9 +
 rtl/fall_through_fifo.sv | 107 ++++++++++
 tb/tb_fall_through_fifo.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fall_through_fifo_pkg.sv
// Shared helpers for the fall-through FIFO.
// Address width derivation used by the FIFO parameter list.
package fall_through_fifo_pkg;

  function automatic int unsigned addr_bits(int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fall_through_fifo.sv
// Single-clock FIFO with optional same-cycle fall-through
// and a zero-depth combinational pass-through mode.
module fall_through_fifo
  import fall_through_fifo_pkg::*;
#(
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 8,
  parameter type         dtype        = logic [DATA_WIDTH-1:0],
  parameter int unsigned ADDR_DEPTH   = addr_bits(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  testmode_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [ADDR_DEPTH-1:0] usage_o,
  input  dtype                  data_i,
  input  logic                  push_i,
  output dtype                  data_o,
  input  logic                  pop_i
);

  if (DEPTH == 0) begin : g_pass
    logic unused_in;
    assign unused_in = ^{clk_i, rst_ni, flush_i, testmode_i};

    assign data_o  = data_i;
    assign empty_o = ~push_i;
    assign full_o  = ~pop_i;
    assign usage_o = '0;

  end else begin : g_fifo
    localparam int unsigned CW = ADDR_DEPTH + 1;
    localparam logic [CW-1:0] FULL_C =
      CW'(DEPTH);
    localparam logic [ADDR_DEPTH-1:0] LAST =
      ADDR_DEPTH'(DEPTH - 1);

    logic [ADDR_DEPTH-1:0] rptr;
    logic [ADDR_DEPTH-1:0] wptr;
    logic [CW-1:0]         count;
    dtype                  mem [DEPTH];

    logic is_zero;
    logic fwd;
    logic thru;
    logic do_push;
    logic do_pop;
    logic unused_tm;

    assign unused_tm = testmode_i;

    assign is_zero = (count == '0);
    assign fwd     = FALL_THROUGH & is_zero & push_i;
    // Element bypasses storage entirely when
    // pushed and popped while empty.
    assign thru    = fwd & pop_i;

    assign full_o  = (count == FULL_C);
    assign empty_o = is_zero & ~fwd;
    assign usage_o = count[ADDR_DEPTH-1:0];
    assign data_o  = fwd ? data_i : mem[rptr];

    assign do_push = push_i & ~full_o & ~thru;
    assign do_pop  = pop_i & ~empty_o & ~thru;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        rptr  <= '0;
        wptr  <= '0;
        count <= '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
          mem[i] <= '0;
        end
      end else if (flush_i) begin
        rptr  <= '0;
        wptr  <= '0;
        count <= '0;
      end else begin
        if (do_push) begin
          mem[wptr] <= data_i;
          wptr <= (wptr == LAST) ? '0 : wptr + 1'b1;
        end
        if (do_pop) begin
          rptr <= (rptr == LAST) ? '0 : rptr + 1'b1;
        end
        unique case ({do_push, do_pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_ni && !flush_i) begin
        assert (!(push_i && full_o))
          else $warning("push while full dropped");
        assert (!(pop_i && empty_o))
          else $warning("pop while empty ignored");
      end
    end
  end

endmodule

// File: tb/tb_fall_through_fifo.sv
// Directed bench for fall_through_fifo: a normal
// DEPTH=4 instance and a fall-through DEPTH=4 instance.
module tb_fall_through_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  int         n_run = 0;
  int         n_fail = 0;

  logic       flush0, push0, pop0, tm0;
  logic [7:0] din0, dout0;
  logic       full0, empty0;
  logic [1:0] use0;

  logic       flush1, push1, pop1, tm1;
  logic [7:0] din1, dout1;
  logic       full1, empty1;
  logic [1:0] use1;

  always #5 clk = ~clk;

  fall_through_fifo #(
    .FALL_THROUGH(1'b0), .DATA_WIDTH(8), .DEPTH(4)
  ) u0 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush0),
    .testmode_i(tm0), .full_o(full0), .empty_o(empty0),
    .usage_o(use0), .data_i(din0), .push_i(push0),
    .data_o(dout0), .pop_i(pop0)
  );

  fall_through_fifo #(
    .FALL_THROUGH(1'b1), .DATA_WIDTH(8), .DEPTH(4)
  ) u1 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush1),
    .testmode_i(tm1), .full_o(full1), .empty_o(empty1),
    .usage_o(use1), .data_i(din1), .push_i(push1),
    .data_o(dout1), .pop_i(pop1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv0(input logic p, input logic q,
                      input logic [7:0] d,
                      input logic f);
    push0 = p; pop0 = q; din0 = d; flush0 = f;
    #1;
  endtask

  task automatic drv1(input logic p, input logic q,
                      input logic [7:0] d);
    push1 = p; pop1 = q; din1 = d;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drv0(0, 0, 8'h00, 0);
    drv1(1, 0, 8'h5A);
    n_run++;
    if (empty1 !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_ft_empty got %b want 0", empty1);
    end
    drv1(0, 0, 8'h00);
    n_run++;
    if (empty0 !== 1'b1 || empty1 !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_empty got %b/%b want 1/1",
               empty0, empty1);
    end
    n_run++;
    if (full0 !== 1'b0 || use0 !== 2'd0) begin
      n_fail++;
      $display("FAIL rst_full_use got %b/%0d want 0/0",
               full0, use0);
    end
    n_run++;
    if (dout0 !== 8'h00) begin
      n_fail++;
      $display("FAIL rst_data got %h want 00", dout0);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic fill4();
    logic [7:0] v [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      drv0(1, 0, v[i], 0);
      tick();
    end
    drv0(0, 0, 8'h00, 0);
  endtask

  task automatic test_fill_drain();
    logic [7:0] v [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    fill4();
    n_run++;
    if (full0 !== 1'b1 || use0 !== 2'd0) begin
      n_fail++;
      $display("FAIL fill_full got %b/%0d want 1/0",
               full0, use0);
    end
    for (int i = 0; i < 4; i++) begin
      drv0(0, 1, 8'h00, 0);
      n_run++;
      if (dout0 !== v[i]) begin
        n_fail++;
        $display("FAIL drain_%0d got %h want %h",
                 i, dout0, v[i]);
      end
      tick();
    end
    drv0(0, 0, 8'h00, 0);
    n_run++;
    if (empty0 !== 1'b1 || use0 !== 2'd0) begin
      n_fail++;
      $display("FAIL drain_empty got %b/%0d want 1/0",
               empty0, use0);
    end
  endtask

  task automatic test_full_drop();
    logic [7:0] v [3] = '{8'h22, 8'h33, 8'h44};
    fill4();
    drv0(1, 0, 8'h55, 0);
    tick();
    drv0(0, 0, 8'h00, 0);
    n_run++;
    if (full0 !== 1'b1 || dout0 !== 8'h11) begin
      n_fail++;
      $display("FAIL drop_push got %b/%h want 1/11",
               full0, dout0);
    end
    drv0(1, 1, 8'h55, 0);
    n_run++;
    if (dout0 !== 8'h11) begin
      n_fail++;
      $display("FAIL full_pushpop_head got %h want 11",
               dout0);
    end
    tick();
    drv0(0, 0, 8'h00, 0);
    n_run++;
    if (use0 !== 2'd3 || full0 !== 1'b0) begin
      n_fail++;
      $display("FAIL full_pushpop_use got %0d/%b want 3/0",
               use0, full0);
    end
    for (int i = 0; i < 3; i++) begin
      drv0(0, 1, 8'h00, 0);
      n_run++;
      if (dout0 !== v[i]) begin
        n_fail++;
        $display("FAIL after_drop_%0d got %h want %h",
                 i, dout0, v[i]);
      end
      tick();
    end
    drv0(0, 0, 8'h00, 0);
    n_run++;
    if (empty0 !== 1'b1) begin
      n_fail++;
      $display("FAIL after_drop_empty got %b want 1",
               empty0);
    end
  endtask

  task automatic test_fall_through();
    drv1(1, 1, 8'hAA);
    n_run++;
    if (dout1 !== 8'hAA || empty1 !== 1'b0) begin
      n_fail++;
      $display("FAIL ft_same got %h/%b want aa/0",
               dout1, empty1);
    end
    tick();
    drv1(0, 0, 8'h00);
    n_run++;
    if (empty1 !== 1'b1 || use1 !== 2'd0) begin
      n_fail++;
      $display("FAIL ft_after got %b/%0d want 1/0",
               empty1, use1);
    end
    drv1(1, 0, 8'hBB);
    tick();
    drv1(0, 0, 8'h00);
    n_run++;
    if (use1 !== 2'd1 || dout1 !== 8'hBB) begin
      n_fail++;
      $display("FAIL ft_store got %0d/%h want 1/bb",
               use1, dout1);
    end
    drv1(0, 1, 8'h00);
    tick();
    drv1(0, 0, 8'h00);
    n_run++;
    if (empty1 !== 1'b1 || full1 !== 1'b0) begin
      n_fail++;
      $display("FAIL ft_drain got %b/%b want 1/0",
               empty1, full1);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] head = 8'd1;
    drv0(1, 0, 8'd1, 0);
    tick();
    drv0(1, 0, 8'd2, 0);
    tick();
    for (int k = 0; k < 10; k++) begin
      drv0(1, 1, 8'(k + 3), 0);
      n_run++;
      if (dout0 !== head) begin
        n_fail++;
        $display("FAIL wrap_data_%0d got %h want %h",
                 k, dout0, head);
      end
      tick();
      head++;
      n_run++;
      if (use0 !== 2'd2) begin
        n_fail++;
        $display("FAIL wrap_use_%0d got %0d want 2",
                 k, use0);
      end
    end
    drv0(0, 1, 8'h00, 0);
    tick();
    drv0(0, 1, 8'h00, 0);
    tick();
    drv0(0, 0, 8'h00, 0);
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      drv0(1, 0, 8'(8'h60 + i), 0);
      tick();
    end
    drv0(1, 0, 8'h77, 1);
    tick();
    drv0(0, 0, 8'h00, 0);
    n_run++;
    if (empty0 !== 1'b1 || use0 !== 2'd0 ||
        full0 !== 1'b0) begin
      n_fail++;
      $display("FAIL flush got e%b u%0d f%b want 1/0/0",
               empty0, use0, full0);
    end
  endtask

  task automatic test_async_reset();
    drv0(1, 0, 8'hA1, 0);
    tick();
    drv0(1, 0, 8'hB2, 0);
    tick();
    drv0(1, 0, 8'hC3, 0);
    tick();
    drv0(0, 0, 8'h00, 0);
    #1;
    rst_n = 1'b0;
    #1;
    n_run++;
    if (empty0 !== 1'b1 || use0 !== 2'd0 ||
        dout0 !== 8'h00) begin
      n_fail++;
      $display("FAIL async_rst got e%b u%0d d%h want 1/0/00",
               empty0, use0, dout0);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    tm0 = 1'b0; tm1 = 1'b0;
    flush1 = 1'b0;
    test_reset();
    test_fill_drain();
    test_full_drop();
    test_fall_through();
    test_wrap();
    test_flush();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
